// File: rtl/control_stall_sequencer.sv
// Stall sequencer: owns core enable; memory wait states, I/O button handshakes, HALT latch.
// Define CTRL_IO_TIMEOUT_EN to abort stuck I/O handshakes after TIMEOUT_CYCLES.
module control_stall_sequencer #(
  parameter int ID_WIDTH        = 7,
  parameter int MEM_WAIT_CYCLES = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                instr_valid,
  input  logic [ID_WIDTH-1:0] ID,
  input  logic                confirmation,
  input  logic                continue_button,
  output logic                enable,
  output logic                is_input,
  output logic                is_output,
  output logic                halted,
  output logic                io_ack,
  output logic                io_timeout
);

  typedef enum logic [2:0] {
    S_RUN, S_MEM_WAIT, S_IO_PRESS, S_IO_RELEASE, S_HALTED
  } state_t;

  typedef enum logic [2:0] {
    C_PLAIN, C_MEM, C_OUT, C_IN, C_PAUSE, C_HALT
  } cls_t;

  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT_CYCLES - 1);
  localparam bit MEM_STALLS = (MEM_WAIT_CYCLES > 0);

  state_t state_q, state_d;
  cls_t   cls;
  logic [3:0] wait_q, wait_d;
  logic is_input_q, is_input_d;
  logic is_output_q, is_output_d;
  logic [SYNC_STAGES-1:0] conf_sync_q, conf_sync_d;
  logic [SYNC_STAGES-1:0] cont_sync_q, cont_sync_d;
  logic btn_s;
  logic [31:0] id_w;

`ifdef CTRL_IO_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_q, to_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    conf_sync_d = {conf_sync_q[SYNC_STAGES-2:0], confirmation};
    cont_sync_d = {cont_sync_q[SYNC_STAGES-2:0], continue_button};
  end

  // PAUSE is the only class with both flags set; it waits on continue
  assign btn_s = (is_input_q & is_output_q) ? cont_sync_q[SYNC_STAGES-1]
                                            : conf_sync_q[SYNC_STAGES-1];

  always_comb begin
    id_w = 32'(ID);
    cls  = C_PLAIN;
    unique case (1'b1)
      (id_w >= 32'd40 && id_w <= 32'd57),
      (id_w == 32'd67), (id_w == 32'd68): cls = C_MEM;
      (id_w == 32'd69):                   cls = C_OUT;
      (id_w == 32'd70):                   cls = C_PAUSE;
      (id_w == 32'd71):                   cls = C_IN;
      (id_w == 32'd75):                   cls = C_HALT;
      default:                            cls = C_PLAIN;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    is_input_d  = is_input_q;
    is_output_d = is_output_q;
    enable      = 1'b0;
    io_ack      = 1'b0;
    io_timeout  = 1'b0;
`ifdef CTRL_IO_TIMEOUT_EN
    to_d        = to_q;
`endif
    unique case (state_q)
      S_RUN: begin
        enable = 1'b1;
`ifdef CTRL_IO_TIMEOUT_EN
        to_d   = '0;
`endif
        if (instr_valid) begin
          unique case (cls)
            C_MEM: begin
              if (MEM_STALLS) begin
                enable  = 1'b0;
                wait_d  = WAIT_LOAD;
                state_d = S_MEM_WAIT;
              end
            end
            C_OUT: begin
              enable      = 1'b0;
              is_output_d = 1'b1;
              state_d     = S_IO_PRESS;
            end
            C_IN: begin
              enable     = 1'b0;
              is_input_d = 1'b1;
              state_d    = S_IO_PRESS;
            end
            C_PAUSE: begin
              enable      = 1'b0;
              is_input_d  = 1'b1;
              is_output_d = 1'b1;
              state_d     = S_IO_PRESS;
            end
            C_HALT: begin
              enable  = 1'b0;
              state_d = S_HALTED;
            end
            default: ;
          endcase
        end
      end
      S_MEM_WAIT: begin
        if (wait_q == 4'd0) begin
          enable  = 1'b1;
          state_d = S_RUN;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_IO_PRESS: begin
        if (btn_s) state_d = S_IO_RELEASE;
      end
      S_IO_RELEASE: begin
        if (!btn_s) begin
          enable      = 1'b1;
          io_ack      = 1'b1;
          is_input_d  = 1'b0;
          is_output_d = 1'b0;
          state_d     = S_RUN;
        end
      end
      S_HALTED: ;
      default: state_d = S_RUN;
    endcase
`ifdef CTRL_IO_TIMEOUT_EN
    // a release on the final cycle still counts as a completion
    if (state_q == S_IO_PRESS || state_q == S_IO_RELEASE) begin
      to_d = to_q + TO_W'(1);
      if (to_q == TO_LAST && !io_ack) begin
        enable      = 1'b1;
        io_timeout  = 1'b1;
        is_input_d  = 1'b0;
        is_output_d = 1'b0;
        state_d     = S_RUN;
      end
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_RUN;
      wait_q      <= '0;
      is_input_q  <= 1'b0;
      is_output_q <= 1'b0;
      conf_sync_q <= '0;
      cont_sync_q <= '0;
`ifdef CTRL_IO_TIMEOUT_EN
      to_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      is_input_q  <= is_input_d;
      is_output_q <= is_output_d;
      conf_sync_q <= conf_sync_d;
      cont_sync_q <= cont_sync_d;
`ifdef CTRL_IO_TIMEOUT_EN
      to_q        <= to_d;
`endif
    end
  end

  assign is_input  = is_input_q;
  assign is_output = is_output_q;
  assign halted    = (state_q == S_HALTED);

endmodule

// File: tb/tb_control_stall_sequencer.sv
// Randomised bench for control_stall_sequencer against a cycle-level reference model.
// Also covers the CTRL_IO_TIMEOUT_EN build when that macro is defined.
module tb_control_stall_sequencer;

  localparam int IW = 7;
  localparam int MW = 2;
  localparam int SS = 2;
  localparam int TO = 16;

  logic clock = 1'b0;
  logic reset, iv, conf, cont;
  logic [IW-1:0] id;
  logic enable, is_input, is_output, halted, io_ack, io_timeout;

  int n_vec = 0;
  int n_bad = 0;

  // reference model: 0 idle, 1 memory stall, 2 await press, 3 await release, 4 halted
  int m_mode = 0;
  int m_left = 0;
  int m_kind = 0;
  int m_age  = 0;
  bit conf_h[$];
  bit cont_h[$];

  bit last_en = 1'b1;
  bit obs_en, obs_ack, obs_to, obs_in, obs_out, obs_h;

  int ids[16] = '{44, 40, 57, 67, 68, 69, 70, 71, 78, 5, 12, 39, 58, 66, 75, 0};

  always #5 clock = ~clock;

  control_stall_sequencer #(
    .ID_WIDTH        (IW),
    .MEM_WAIT_CYCLES (MW),
    .SYNC_STAGES     (SS),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .instr_valid     (iv),
    .ID              (id),
    .confirmation    (conf),
    .continue_button (cont),
    .enable          (enable),
    .is_input        (is_input),
    .is_output       (is_output),
    .halted          (halted),
    .io_ack          (io_ack),
    .io_timeout      (io_timeout)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // 0 plain, 1 mem, 2 out, 3 in, 4 pause, 5 halt
  function automatic int id_class(input int v);
    if (v inside {[40:57], 67, 68}) return 1;
    if (v == 69) return 2;
    if (v == 71) return 3;
    if (v == 70) return 4;
    if (v == 75) return 5;
    return 0;
  endfunction

  function automatic bit synced(input bit h[$]);
    if (h.size() < SS) return 1'b0;
    return h[SS-1];
  endfunction

  function automatic logic [IW-1:0] pick();
    int r, v;
    r = $urandom_range(0, 15);
    v = ids[r];
    if (r == 15) v = $urandom_range(0, 127);
    if (v == 75 && $urandom_range(0, 3) != 0) v = 12;
    return IW'(v);
  endfunction

  // call at the falling edge with inputs already driven
  task automatic step();
    bit e_en, e_ack, e_to, e_in, e_out, e_h, btn, timed, iv_s;
    int c;
    #1;
    btn   = (m_kind == 3) ? synced(cont_h) : synced(conf_h);
    timed = 1'b0;
`ifdef CTRL_IO_TIMEOUT_EN
    timed = (m_mode == 2 || m_mode == 3) && m_age == TO && !(m_mode == 3 && !btn);
`endif
    c     = id_class(int'(id));
    iv_s  = iv;
    e_h   = (m_mode == 4);
    e_out = (m_mode == 2 || m_mode == 3) && (m_kind == 1 || m_kind == 3);
    e_in  = (m_mode == 2 || m_mode == 3) && (m_kind == 2 || m_kind == 3);
    e_ack = (m_mode == 3) && !btn;
    e_to  = timed;
    case (m_mode)
      0: e_en = !(iv_s && ((c == 1 && MW > 0) || c >= 2));
      1: e_en = (m_left == 1);
      2: e_en = timed;
      3: e_en = !btn || timed;
      default: e_en = 1'b0;
    endcase
    check("enable", enable, e_en);
    check("io_ack", io_ack, e_ack);
    check("io_timeout", io_timeout, e_to);
    check("is_input", is_input, e_in);
    check("is_output", is_output, e_out);
    check("halted", halted, e_h);
    obs_en  = enable;
    obs_ack = io_ack;
    obs_to  = io_timeout;
    obs_in  = is_input;
    obs_out = is_output;
    obs_h   = halted;
    last_en = e_en;
    @(posedge clock);
    case (m_mode)
      0: if (iv_s) begin
        if (c == 1 && MW > 0) begin
          m_mode = 1;
          m_left = MW;
        end else if (c >= 2 && c <= 4) begin
          m_mode = 2;
          m_kind = c - 1;
          m_age  = 1;
        end else if (c == 5) begin
          m_mode = 4;
        end
      end
      1: begin
        m_left--;
        if (e_en) m_mode = 0;
      end
      2: begin
        if (timed) m_mode = 0;
        else begin
          if (btn) m_mode = 3;
          m_age++;
        end
      end
      3: begin
        if (e_en) m_mode = 0;
        else m_age++;
      end
      default: ;
    endcase
    conf_h.push_front(conf);
    cont_h.push_front(cont);
    if (conf_h.size() > SS) void'(conf_h.pop_back());
    if (cont_h.size() > SS) void'(cont_h.pop_back());
    @(negedge clock);
  endtask

  task automatic rst_checks();
    check("rst_enable", enable, 1);
    check("rst_is_input", is_input, 0);
    check("rst_is_output", is_output, 0);
    check("rst_halted", halted, 0);
    check("rst_io_ack", io_ack, 0);
    check("rst_io_timeout", io_timeout, 0);
  endtask

  // asserted mid-cycle to exercise the asynchronous path
  task automatic do_reset();
    #2;
    reset = 1'b1;
    iv    = 1'b0;
    #1;
    rst_checks();
    m_mode = 0;
    m_left = 0;
    m_kind = 0;
    m_age  = 0;
    conf_h.delete();
    cont_h.delete();
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset   = 1'b0;
    last_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit [2:0] seq;
    int k, hold, halt_cnt;
    reset = 1'b1;
    iv    = 1'b0;
    id    = '0;
    conf  = 1'b0;
    cont  = 1'b0;
    #1;
    rst_checks();
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // memory instruction then a plain one
    iv = 1'b1;
    id = IW'(44);
    for (int i = 0; i < 3; i++) begin
      step();
      seq[2-i] = obs_en;
    end
    check("mem_seq", seq, 3'b001);
    id = IW'(12);
    step();
    check("plain_en", obs_en, 1);
    iv = 1'b0;
    step();

    // OUTPUT handshake and release latency
    iv = 1'b1;
    id = IW'(69);
    step();
    iv   = 1'b0;
    conf = 1'b1;
    repeat (5) step();
    conf = 1'b0;
    k = 0;
    obs_ack = 1'b0;
    while (!obs_ack && k < 30) begin
      step();
      k++;
    end
    check("out_ack_lat", k, SS + 1);
    check("out_ack_is_output", obs_out, 1);
    check("out_ack_is_input", obs_in, 0);

    // PAUSE ignores confirmation, completes on continue
    iv = 1'b1;
    id = IW'(70);
    step();
    iv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      conf = ~conf;
      step();
    end
    check("pause_stalled", obs_en, 0);
    conf = 1'b0;
    cont = 1'b1;
    repeat (4) step();
    cont = 1'b0;
    k = 0;
    obs_ack = 1'b0;
    while (!obs_ack && k < 30) begin
      step();
      k++;
    end
    check("pause_ack_seen", obs_ack, 1);
    check("pause_io", {obs_in, obs_out}, 2'b11);

    // HALT holds through IDs and buttons
    iv = 1'b1;
    id = IW'(75);
    step();
    hold = 0;
    for (int i = 0; i < 100; i++) begin
      id   = pick();
      conf = 1'($urandom_range(0, 1));
      cont = 1'($urandom_range(0, 1));
      step();
      if (obs_h && !obs_en) hold++;
    end
    check("halt_hold", hold, 100);
    conf = 1'b0;
    cont = 1'b0;
    do_reset();

    // reset during IO_RELEASE with the button still held
    iv = 1'b1;
    id = IW'(71);
    step();
    iv   = 1'b0;
    conf = 1'b1;
    k = 0;
    while (m_mode != 3 && k < 20) begin
      step();
      k++;
    end
    check("in_reached_release", m_mode, 3);
    do_reset();
    iv = 1'b1;
    id = IW'(5);
    step();
    check("post_rst_en", obs_en, 1);
    iv   = 1'b0;
    conf = 1'b0;
    repeat (SS + 1) step();

`ifdef CTRL_IO_TIMEOUT_EN
    iv = 1'b1;
    id = IW'(69);
    step();
    iv = 1'b0;
    k = 0;
    obs_to = 1'b0;
    while (!obs_to && k < 40) begin
      step();
      k++;
    end
    check("to_lat", k, TO);
    check("to_ack", obs_ack, 0);
    check("to_en", obs_en, 1);
`endif

    // random traffic
    halt_cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) conf = ~conf;
      if ($urandom_range(0, 7) == 0) cont = ~cont;
      if (last_en) begin
        if ($urandom_range(0, 2) == 0) iv = 1'b0;
        else begin
          iv = 1'b1;
          id = pick();
        end
      end
      step();
      if (m_mode == 4) halt_cnt++;
      if (halt_cnt > 20 || $urandom_range(0, 299) == 0) begin
        halt_cnt = 0;
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/control_stall_sequencer.md
Name: control_stall_sequencer

Overview:
- Sequential companion to the instruction-ID control decoder.
- Owns the core's `enable` (advance) signal: inserts parameterised memory wait states, runs press/release handshakes for OUTPUT/INPUT/PAUSE, and latches HALT.
- Sits between the decoder and the pipeline/PC update logic. Generalises the decoder's combinational `enable = confirmation` gating into a clocked handshake with synchronised buttons and configurable ID width.

Parameters:
- ID_WIDTH, 7, width of instruction ID bus.
- MEM_WAIT_CYCLES, 2, extra stall cycles per memory-class instruction (0..15).
- SYNC_STAGES, 2, synchroniser depth on button inputs (>=2).
- TIMEOUT_CYCLES, 1000000, I/O handshake timeout (optional feature only).

Ports:
- clock, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- instr_valid, input, 1: ID holds a new decoded instruction this cycle.
- ID, input, ID_WIDTH: instruction ID; upstream holds it stable while enable=0.
- confirmation, input, 1: async push button for OUTPUT/INPUT.
- continue_button, input, 1: async push button for PAUSE.
- enable, output, 1: core commits/advances this cycle.
- is_input, output, 1: input device selected.
- is_output, output, 1: output display selected.
- halted, output, 1: HALT latched.
- io_ack, output, 1: one-cycle pulse on handshake completion.
- io_timeout, output, 1: one-cycle pulse on handshake abort (optional feature).

Behaviour:
- ID classes (fixed codes):
  - MEM: 40–57, 67, 68.
  - OUT: 69.
  - PAUSE: 70.
  - IN: 71.
  - HALT: 75.
  - Everything else is PLAIN, including 78 (leave-BIOS does not halt).
- Buttons pass through SYNC_STAGES flops (reset 0). FSM uses the synchronised levels only.
- States: RUN, MEM_WAIT, IO_PRESS, IO_RELEASE, HALTED. Reset state is RUN.
- Reset values: enable=1 (RUN, no instr), is_input=0, is_output=0, halted=0, io_ack=0, io_timeout=0, wait counter=0.
- RUN:
  - enable=1 unless instr_valid is high and the class is MEM (with MEM_WAIT_CYCLES>0), OUT, IN, PAUSE or HALT; then enable=0 that cycle.
  - MEM -> MEM_WAIT, counter loads MEM_WAIT_CYCLES-1.
  - OUT/IN/PAUSE -> IO_PRESS, class latched.
  - HALT -> HALTED.
  - PLAIN, or no instr_valid: stay in RUN.
- MEM_WAIT:
  - enable=0 while counter!=0; counter decrements.
  - When counter==0: enable=1 for that cycle, next state RUN.
  - Total MEM instruction latency is MEM_WAIT_CYCLES+1 cycles. With MEM_WAIT_CYCLES=0, MEM behaves as PLAIN.
- IO_PRESS:
  - enable=0. Waits for the selected synchronised button (confirmation for OUT/IN, continue_button for PAUSE) to be high, then -> IO_RELEASE.
  - A button already high on entry counts as a press.
- IO_RELEASE:
  - enable=0 while the button is high.
  - On the first low sample: enable=1 and io_ack=1 for that cycle, next state RUN.
- is_input/is_output are registered and valid in IO_PRESS and IO_RELEASE, including the completion cycle:
  - OUT -> is_output=1.
  - IN -> is_input=1.
  - PAUSE -> both 1.
  - Both 0 in all other states.
- HALTED: enable=0 and halted=1 permanently; instr_valid is ignored. Only reset exits.
- The non-selected button is ignored in every state.
- instr_valid is ignored in every state other than RUN.
- Reset asserted mid-wait or mid-handshake immediately forces RUN and the reset values; a button held through reset release is not treated as a new press until an instruction enters IO_PRESS.

Optional Feature:
- Macro CTRL_IO_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in IO_PRESS/IO_RELEASE, cleared on IO_PRESS entry.
  - When the counter reaches TIMEOUT_CYCLES-1 without completion: enable=1 and io_timeout=1 for that cycle, io_ack=0, next state RUN.
  - Completion on the same cycle as the timeout wins: io_ack=1, io_timeout=0.
- Undefined: no counter; the handshake waits indefinitely; io_timeout is tied 0.

Test Plan:
- MEM_WAIT_CYCLES=2, instr_valid with ID=44 -> enable 0,0,1 over three cycles, back to RUN; ID=12 -> enable stays 1.
- ID=69, confirmation pulsed high 5 cycles then low -> is_output=1 throughout; enable=1 and io_ack=1 exactly SYNC_STAGES+1 cycles after the falling edge; is_input=0.
- ID=70 with confirmation toggling and continue_button low -> no progress; then press/release continue_button -> completes with is_input=is_output=1.
- ID=75 -> halted=1 and enable=0 for 100 cycles despite further IDs and buttons; reset -> halted=0, enable=1.
- ID=71, reset asserted while in IO_RELEASE -> outputs return to reset values asynchronously; next ID=5 executes with enable=1.
- CTRL_IO_TIMEOUT_EN with TIMEOUT_CYCLES=16, ID=69, no press -> io_timeout=1 and enable=1 on the 16th cycle after entry, io_ack=0.
